program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_word_assembler.sv | 37 +++
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, word geometry
// and the instruction-memory address helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] ADDR_STRIDE    = 32'd4;

    // Byte address of word number idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [7:0]  idx);
        return base + (ADDR_STRIDE * {24'd0, idx});
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a most-significant-byte-first byte stream into 32-bit words.
// o_word is the word as it will look once the current byte is accepted,
// so the loader can latch a complete word on the edge that takes its
// last byte.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [23:0] r_shift;
    logic [1:0]  r_count;

    // Shift accepted bytes in at the low end and count them modulo a word.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= 24'd0;
            r_count <= 2'd0;
        end else if (i_accept) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_count <= r_count + 2'd1;
        end else begin
            r_shift <= r_shift;
            r_count <= r_count;
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_accept && (r_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a program from a byte stream into instruction memory, holding the
// CPU in reset until every word has been written, then releasing it.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        done
);

    state_t      r_state;
    logic [7:0]  r_word_count;
    logic [7:0]  r_word_index;
    logic        r_byte_ready;
    logic        r_initialize;
    logic        r_cpu_rst;
    logic        r_done;
    logic [31:0] r_data;
    logic [31:0] r_addr;

    logic        w_start_ok;
    logic        w_accept;
    logic [31:0] w_word;
    logic        w_word_ready;

    // A start is honoured only when no load is in flight.
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_accept   = byte_valid && r_byte_ready;

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_accept     (w_accept),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // Load sequencing FSM; outputs are registered alongside the state so
    // each reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_word_count <= 8'd0;
            r_word_index <= 8'd0;
            r_byte_ready <= 1'b0;
            r_initialize <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_data       <= 32'h0000_0000;
            r_addr       <= BASE_ADDR;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (start) begin
                        r_word_count <= word_count;
                        r_word_index <= 8'd0;
                        r_data       <= 32'h0000_0000;
                        r_addr       <= BASE_ADDR;
                        r_cpu_rst    <= 1'b1;
                        r_done       <= 1'b0;
                        if (word_count != 8'd0) begin
                            r_state      <= ST_COLLECT;
                            r_byte_ready <= 1'b1;
                            r_initialize <= 1'b1;
                        end else begin
                            r_state      <= ST_RELEASE;
                            r_byte_ready <= 1'b0;
                            r_initialize <= 1'b0;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_COLLECT: begin
                    if (w_word_ready) begin
                        r_state      <= ST_WRITE;
                        r_byte_ready <= 1'b0;
                        r_data       <= w_word;
                        r_addr       <= word_addr(BASE_ADDR, r_word_index);
                    end else begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_WRITE: begin
                    r_word_index <= r_word_index + 8'd1;
                    if ((r_word_index + 8'd1) == r_word_count) begin
                        r_state      <= ST_RELEASE;
                        r_initialize <= 1'b0;
                    end else begin
                        r_state      <= ST_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state   <= ST_RUN;
                    r_cpu_rst <= 1'b0;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_initialize <= 1'b0;
                    r_cpu_rst    <= 1'b1;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready                     = r_byte_ready;
    assign initialize                     = r_initialize;
    assign cpu_rst                        = r_cpu_rst;
    assign done                           = r_done;
    assign instruction_initialize_data    = r_data;
    assign instruction_initialize_address = r_addr;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one instance at base 0 and one at the
// top of the address space share the same stimulus.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        a_ready, a_init, a_cpu_rst, a_done;
    logic [31:0] a_data, a_addr;
    logic        b_ready, b_init, b_cpu_rst, b_done;
    logic [31:0] b_data, b_addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int init_cnt = 0;
    int t0;
    logic [31:0] wa_data[$];
    logic [31:0] wa_addr[$];
    logic [31:0] wb_addr[$];

    program_loader #(.BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(a_ready),
        .initialize(a_init), .instruction_initialize_data(a_data),
        .instruction_initialize_address(a_addr), .cpu_rst(a_cpu_rst), .done(a_done)
    );

    program_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_ready),
        .initialize(b_init), .instruction_initialize_data(b_data),
        .instruction_initialize_address(b_addr), .cpu_rst(b_cpu_rst), .done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write cycle (initialize high, byte_ready low) of both instances.
    always @(negedge clk) begin
        if (a_init) init_cnt <= init_cnt + 1;
        if (a_init && !a_ready) begin
            wa_data.push_back(a_data);
            wa_addr.push_back(a_addr);
        end
        if (b_init && !b_ready) wb_addr.push_back(b_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa_data.delete();
        wa_addr.delete();
        wb_addr.delete();
    endtask

    // Present a byte and hold it until the loader takes it.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!a_ready && n < 20) begin
            tick();
            n++;
        end
        chk("push_wait", 32'(n < 20), 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; word_count = 8'd0; byte_valid = 1'b0; byte_data = 8'd0;
        tick();
        tick();
        chk("rst_ready",   32'(a_ready),   32'd0);
        chk("rst_init",    32'(a_init),    32'd0);
        chk("rst_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("rst_done",    32'(a_done),    32'd0);
        chk("rst_data",    a_data,         32'h0);
        chk("rst_addr_b",  b_addr,         32'hFFFF_FFFC);
        rst = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h55;   // ignored while idle
        tick();
        chk("idle_ready",  32'(a_ready),   32'd0);
        clear_logs();

        // Two words back-to-back.
        start = 1'b1; word_count = 8'd2; byte_data = 8'h20;
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("collect_init", 32'(a_init),  32'd1);
        chk("collect_first_addr", a_addr, 32'h0);
        push(8'h20); push(8'h08); push(8'h00); push(8'h05);
        push(8'h20); push(8'h09); push(8'h00); push(8'h07);
        byte_valid = 1'b0;
        tick();
        chk("rel_init",    32'(a_init),    32'd0);
        chk("rel_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("rel_done",    32'(a_done),    32'd0);
        tick();
        chk("run_latency", 32'(cyc - t0),  32'd11);
        chk("run_done",    32'(a_done),    32'd1);
        chk("run_cpu_rst", 32'(a_cpu_rst), 32'd0);
        chk("w2_count",    32'(wa_data.size()), 32'd2);
        chk("w2_d0", wa_data[0], 32'h2008_0005);
        chk("w2_a0", wa_addr[0], 32'h0000_0000);
        chk("w2_d1", wa_data[1], 32'h2009_0007);
        chk("w2_a1", wa_addr[1], 32'h0000_0004);
        chk("wrap_count",  32'(wb_addr.size()), 32'd2);
        chk("wrap_a0", wb_addr[0], 32'hFFFF_FFFC);
        chk("wrap_a1", wb_addr[1], 32'h0000_0000);
        chk("run_hold_data", a_data, 32'h2009_0007);
        clear_logs();

        // One word with byte_valid toggling every cycle (also a reload from RUN).
        start = 1'b1; word_count = 8'd1;
        tick();
        start = 1'b0;
        chk("reload_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("reload_done",    32'(a_done),    32'd0);
        byte_valid = 1'b1; byte_data = 8'hDE; tick();
        byte_valid = 1'b0; tick();
        chk("stall_ready", 32'(a_ready), 32'd1);
        byte_valid = 1'b1; byte_data = 8'hAD; tick();
        byte_valid = 1'b0; tick();
        byte_valid = 1'b1; byte_data = 8'hBE; tick();
        byte_valid = 1'b0; tick();
        byte_valid = 1'b1; byte_data = 8'hEF; tick();
        byte_valid = 1'b0;
        chk("tog_wr_ready", 32'(a_ready), 32'd0);
        chk("tog_wr_init",  32'(a_init),  32'd1);
        chk("tog_wr_data",  a_data,       32'hDEAD_BEEF);
        chk("tog_wr_addr",  a_addr,       32'h0);
        chk("tog_wr_addr_b", b_addr,      32'hFFFF_FFFC);
        tick();
        tick();
        chk("tog_done",  32'(a_done), 32'd1);
        chk("tog_count", 32'(wa_data.size()), 32'd1);
        clear_logs();

        // Zero-length load: straight to release, no write, bytes ignored.
        init_cnt = 0;
        byte_valid = 1'b1; byte_data = 8'hFF;
        start = 1'b1; word_count = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_rel_done",    32'(a_done),    32'd0);
        chk("zero_rel_cpu_rst", 32'(a_cpu_rst), 32'd1);
        tick();
        chk("zero_run_done",    32'(a_done),    32'd1);
        chk("zero_init_cnt",    32'(init_cnt),  32'd0);
        chk("zero_writes",      32'(wa_data.size()), 32'd0);
        byte_valid = 1'b0;

        // Reset mid-word, then a clean one-word load.
        start = 1'b1; word_count = 8'd1;
        tick();
        start = 1'b0;
        push(8'hAA); push(8'hBB);
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready",   32'(a_ready),   32'd0);
        chk("mid_rst_init",    32'(a_init),    32'd0);
        chk("mid_rst_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("mid_rst_data",    a_data,         32'h0);
        clear_logs();
        start = 1'b1; word_count = 8'd1;
        tick();
        start = 1'b0;
        push(8'h11); push(8'h11); push(8'h22); push(8'h22);
        byte_valid = 1'b0;
        chk("post_rst_data", a_data, 32'h1111_2222);
        chk("post_rst_addr", a_addr, 32'h0);
        tick();
        tick();
        chk("post_rst_done", 32'(a_done), 32'd1);

        // Reload from RUN with a start pulse during COLLECT that must be ignored.
        clear_logs();
        start = 1'b1; word_count = 8'd1;
        tick();
        chk("rl_ready", 32'(a_ready), 32'd1);
        start = 1'b1; word_count = 8'd3; byte_valid = 1'b1; byte_data = 8'h01;
        tick();
        start = 1'b0;
        push(8'h02); push(8'h03); push(8'h04);
        byte_valid = 1'b0;
        chk("rl_data", a_data, 32'h0102_0304);
        chk("rl_addr", a_addr, 32'h0);
        tick();
        chk("rl_release_ready", 32'(a_ready), 32'd0);
        chk("rl_release_init",  32'(a_init),  32'd0);
        tick();
        chk("rl_done",   32'(a_done), 32'd1);
        chk("rl_writes", 32'(wa_data.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
